// File: rtl/mdu_arbiter.sv
// rtl/mdu_arbiter.sv - round-robin sequencer sharing one multi-cycle MDU between two requesters
module mdu_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    input  logic [3:0]  req_op_0,
    input  logic [3:0]  req_op_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    output logic        resp_valid_0,
    output logic        resp_valid_1,
    output logic [31:0] resp_hi,
    output logic [31:0] resp_lo,
    output logic        resp_err,
    output logic        mdu_start,
    output logic [3:0]  mdu_op,
    output logic [31:0] mdu_d1,
    output logic [31:0] mdu_d2,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        err_sticky
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             owner_id;
    logic [CNT_W-1:0] wait_cnt;

    logic             grant_id;
    logic             accept;
    logic [3:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;

    // Arbitration: a lone requester wins outright, a tie goes to the port that did not win last.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req_valid_1;
        end
        accept      = (state == IDLE) && (req_valid_0 || req_valid_1) && !reset;
        sel_op      = grant_id ? req_op_1 : req_op_0;
        sel_a       = grant_id ? req_a_1  : req_a_0;
        sel_b       = grant_id ? req_b_1  : req_b_0;
        req_ready_0 = accept && !grant_id;
        req_ready_1 = accept && grant_id;
    end

    // Sequencer: accept, issue to the MDU, wait on busy with a watchdog, then strobe the owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner_id     <= 1'b0;
            wait_cnt     <= '0;
            mdu_start    <= 1'b0;
            mdu_op       <= '0;
            mdu_d1       <= '0;
            mdu_d2       <= '0;
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            resp_hi      <= '0;
            resp_lo      <= '0;
            resp_err     <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mdu_op     <= sel_op;
                        mdu_d1     <= sel_a;
                        mdu_d2     <= sel_b;
                        owner_id   <= grant_id;
                        last_grant <= grant_id;
                        if (sel_op == 4'd0) begin
                            // READ returns the current HI/LO without touching the MDU.
                            resp_hi      <= mdu_hi;
                            resp_lo      <= mdu_lo;
                            resp_err     <= 1'b0;
                            resp_valid_0 <= !grant_id;
                            resp_valid_1 <= grant_id;
                            state        <= RESP;
                        end else begin
                            mdu_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mdu_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!mdu_busy) begin
                        resp_hi      <= mdu_hi;
                        resp_lo      <= mdu_lo;
                        resp_err     <= 1'b0;
                        resp_valid_0 <= !owner_id;
                        resp_valid_1 <= owner_id;
                        state        <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Watchdog expired: report the error and leave the result registers untouched.
                        resp_err     <= 1'b1;
                        err_sticky   <= 1'b1;
                        resp_valid_0 <= !owner_id;
                        resp_valid_1 <= owner_id;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    resp_valid_0 <= 1'b0;
                    resp_valid_1 <= 1'b0;
                    resp_err     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_arbiter.sv
// tb/tb_mdu_arbiter.sv - directed self-checking bench for mdu_arbiter with a behavioural MDU
module tb_mdu_arbiter;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic [3:0]  req_op_0 = '0, req_op_1 = '0;
    logic [31:0] req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
    logic        req_ready_0, req_ready_1;
    logic        resp_valid_0, resp_valid_1;
    logic [31:0] resp_hi, resp_lo;
    logic        resp_err;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_d1, mdu_d2;
    logic        mdu_busy;
    logic [31:0] mdu_hi, mdu_lo;
    logic        err_sticky;

    int tests = 0;
    int fails = 0;
    int both_ready_cnt = 0;

    mdu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_err(resp_err),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_d1(mdu_d1), .mdu_d2(mdu_d2),
        .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // Behavioural MDU. Op codes: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 fdiv, 8 hang.
    logic [63:0] mdu_pend;
    int          mdu_cnt;

    function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] x, y, q, r;
        x = a;
        y = b;
        q = x / y;
        r = x % y;
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mdu_busy <= 1'b0;
            mdu_hi   <= '0;
            mdu_lo   <= '0;
            mdu_cnt  <= 0;
            mdu_pend <= '0;
        end else if (mdu_start) begin
            case (mdu_op)
                4'd1: begin mdu_pend <= mul_s(mdu_d1, mdu_d2); mdu_busy <= 1'b1; mdu_cnt <= 5; end
                4'd2: begin mdu_pend <= {32'd0, mdu_d1} * {32'd0, mdu_d2}; mdu_busy <= 1'b1; mdu_cnt <= 5; end
                4'd3: begin mdu_pend <= div_s(mdu_d1, mdu_d2); mdu_busy <= 1'b1; mdu_cnt <= 10; end
                4'd4: begin mdu_pend <= {mdu_d1 % mdu_d2, mdu_d1 / mdu_d2}; mdu_busy <= 1'b1; mdu_cnt <= 10; end
                4'd5: mdu_hi <= mdu_d1;
                4'd6: mdu_lo <= mdu_d1;
                4'd7: begin mdu_pend <= {32'd0, mdu_d1 / mdu_d2}; mdu_busy <= 1'b1; mdu_cnt <= 3; end
                4'd8: begin mdu_busy <= 1'b1; mdu_cnt <= 0; end
                default: ;
            endcase
        end else if (mdu_busy && mdu_cnt != 0) begin
            if (mdu_cnt == 1) begin
                mdu_busy <= 1'b0;
                mdu_hi   <= mdu_pend[63:32];
                mdu_lo   <= mdu_pend[31:0];
            end
            mdu_cnt <= mdu_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (req_ready_0 && req_ready_1) both_ready_cnt <= both_ready_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int port, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req_valid_0 = v; req_op_0 = op; req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = v; req_op_1 = op; req_a_1 = a; req_b_1 = b;
        end
    endtask

    function automatic logic rdy(input int port);
        return (port == 0) ? req_ready_0 : req_ready_1;
    endfunction

    function automatic logic rv(input int port);
        return (port == 0) ? resp_valid_0 : resp_valid_1;
    endfunction

    // Issue one request on a port; report latency from accept cycle to resp_valid, start pulses and stray responses.
    task automatic do_req(input string tag, input int port, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int starts, output int start_at, output int other);
        int n;
        drive(port, 1'b1, op, a, b);
        #1;
        n = 0;
        while (!rdy(port) && n < 40) begin
            step();
            n++;
        end
        check({tag, "_accept"}, 64'(rdy(port)), 64'd1);
        step();
        drive(port, 1'b0, 4'd0, 32'd0, 32'd0);
        lat = 1;
        starts = 0;
        start_at = 0;
        other = 0;
        while (1) begin
            if (mdu_start) begin
                starts++;
                start_at = lat;
            end
            if (rv(1 - port)) other++;
            if (rv(port) || lat >= 60) break;
            step();
            lat++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int lat, starts, start_at, other, p, n, seen;

    initial begin
        // Reset state
        do_reset();
        check("rst_ready0", 64'(req_ready_0), 64'd0);
        check("rst_ready1", 64'(req_ready_1), 64'd0);
        check("rst_resp", 64'({resp_valid_0, resp_valid_1, resp_err}), 64'd0);
        check("rst_start", 64'(mdu_start), 64'd0);
        check("rst_latch", {28'd0, mdu_op, mdu_d1}, 64'd0);
        check("rst_d2", 64'(mdu_d2), 64'd0);
        check("rst_hilo", {resp_hi, resp_lo}, 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);

        // Signed mult on port 0: -2 * 3
        do_req("mult", 0, 4'd1, 32'hFFFF_FFFE, 32'd3, lat, starts, start_at, other);
        check("mult_lat", 64'(lat), 64'd8);
        check("mult_starts", 64'(starts), 64'd1);
        check("mult_start_at", 64'(start_at), 64'd1);
        check("mult_hi", 64'(resp_hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(resp_lo), 64'hFFFF_FFFA);
        check("mult_err", 64'(resp_err), 64'd0);
        check("mult_other", 64'(other), 64'd0);
        step();
        check("mult_strobe_1cyc", 64'(resp_valid_0), 64'd0);
        check("mult_d1_hold", 64'(mdu_d1), 64'hFFFF_FFFE);
        check("mult_hilo_persist", {resp_hi, resp_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // Both ports continuously valid with divu 100/7: grants alternate from port 0
        do_reset();
        drive(0, 1'b1, 4'd4, 32'd100, 32'd7);
        drive(1, 1'b1, 4'd4, 32'd100, 32'd7);
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req_ready_0 || req_ready_1) && n < 40) begin
                step();
                n++;
            end
            p = req_ready_1 ? 1 : 0;
            check("rr_grant", 64'(p), 64'(k % 2));
            check("rr_onehot", 64'(req_ready_0 & req_ready_1), 64'd0);
            step();
            lat = 1;
            while (!rv(p) && lat < 40) begin
                step();
                lat++;
            end
            check("rr_lat", 64'(lat), 64'd13);
            check("rr_hilo", {resp_hi, resp_lo}, {32'd2, 32'd14});
        end
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        step();

        // mthi on port 1, then READ
        do_req("mthi", 1, 4'd5, 32'h1234_5678, 32'd0, lat, starts, start_at, other);
        check("mthi_lat", 64'(lat), 64'd3);
        check("mthi_other", 64'(other), 64'd0);
        step();
        do_req("read", 1, 4'd0, 32'd0, 32'd0, lat, starts, start_at, other);
        check("read_lat", 64'(lat), 64'd1);
        check("read_nostart", 64'(starts), 64'd0);
        check("read_hilo", {resp_hi, resp_lo}, {32'h1234_5678, 32'd14});

        // Hung MDU: watchdog fires after TIMEOUT wait cycles
        step();
        do_req("hang", 0, 4'd8, 32'd1, 32'd1, lat, starts, start_at, other);
        check("hang_lat", 64'(lat), 64'(TIMEOUT + 2));
        check("hang_err", 64'(resp_err), 64'd1);
        check("hang_sticky", 64'(err_sticky), 64'd1);
        check("hang_hilo_kept", {resp_hi, resp_lo}, {32'h1234_5678, 32'd14});
        step();
        check("hang_err_clear", 64'(resp_err), 64'd0);
        do_req("post_hang", 0, 4'd2, 32'd3, 32'd4, lat, starts, start_at, other);
        check("post_hang_lat", 64'(lat), 64'd8);
        check("post_hang_hilo", {resp_hi, resp_lo}, 64'd12);
        check("post_hang_err", 64'(resp_err), 64'd0);
        check("post_hang_sticky", 64'(err_sticky), 64'd1);
        step();

        // Reset during WAIT of a div
        drive(0, 1'b1, 4'd3, 32'd100, 32'd7);
        #1;
        n = 0;
        while (!req_ready_0 && n < 40) begin
            step();
            n++;
        end
        check("rw_accept", 64'(req_ready_0), 64'd1);
        step();
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("rw_resp", 64'({resp_valid_0, resp_valid_1, resp_err}), 64'd0);
        check("rw_start", 64'(mdu_start), 64'd0);
        check("rw_latch", {28'd0, mdu_op, mdu_d1}, 64'd0);
        check("rw_hilo", {resp_hi, resp_lo}, 64'd0);
        check("rw_sticky", 64'(err_sticky), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (resp_valid_0 || resp_valid_1) seen++;
        end
        check("rw_no_resp", 64'(seen), 64'd0);
        do_req("multu", 0, 4'd2, 32'hFFFF_FFFF, 32'd2, lat, starts, start_at, other);
        check("multu_lat", 64'(lat), 64'd8);
        check("multu_hilo", {resp_hi, resp_lo}, {32'd1, 32'hFFFF_FFFE});
        step();

        // Gap: port 1 stays valid, port 0 drops for one cycle
        do_req("gap_pre", 1, 4'd0, 32'd0, 32'd0, lat, starts, start_at, other);
        check("gap_pre_lat", 64'(lat), 64'd1);
        step();
        drive(0, 1'b1, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b1, 4'd0, 32'd0, 32'd0);
        #1;
        check("gap_first_p0", {62'd0, req_ready_1, req_ready_0}, 64'd1);
        step();
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        check("gap_resp0", 64'(resp_valid_0), 64'd1);
        step();
        check("gap_p1_wins", {62'd0, req_ready_1, req_ready_0}, 64'd2);
        step();
        drive(0, 1'b1, 4'd0, 32'd0, 32'd0);
        check("gap_resp1", 64'(resp_valid_1), 64'd1);
        step();
        check("gap_p0_back", {62'd0, req_ready_1, req_ready_0}, 64'd1);
        step();
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        step();
        step();

        check("never_both_ready", 64'(both_ready_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_arbiter.md
Name: mdu_arbiter

Overview:
- Sequencer and arbiter that shares the single multi-cycle multiply/divide unit (MDU) between two requesters, e.g. the E-stage pipeline (port 0) and a secondary master such as a debug/coprocessor port (port 1).
- Accepts one operation at a time using a valid/ready handshake and round-robin arbitration.
- Drives the MDU start/op/operand inputs and waits on MDU busy.
- Returns HI/LO to the winning requester with a one-cycle response strobe and a watchdog error.

Parameters:
- TIMEOUT, 32, maximum WAIT-state cycles before the operation is aborted with an error (>=16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  request pending; held until the matching req_ready
- req_op_0 / req_op_1  in  4  MDU op code; 0 means READ, which returns current HI/LO without starting the MDU
- req_a_0 / req_a_1, req_b_0 / req_b_1  in  32  operands D1 and D2
- req_ready_0 / req_ready_1  out  1  combinational accept strobe; at most one high per cycle
- resp_valid_0 / resp_valid_1  out  1  one-cycle completion strobe to the owning requester
- resp_hi, resp_lo  out  32  result registers, valid while a resp_valid is high
- resp_err  out  1  high with resp_valid if the operation timed out
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_op  out  4  latched op
- mdu_d1, mdu_d2  out  32  latched operands
- mdu_busy  in  1  MDU busy
- mdu_hi, mdu_lo  in  32  MDU HI/LO
- err_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (clk and reset as already decided):
  - state IDLE.
  - All outputs 0; latched op and operands 0.
  - Round-robin pointer last_grant=1, so port 0 wins the first tie.
  - WAIT counter 0; err_sticky 0.
  - Reset mid-operation abandons the operation with no response. The MDU shares the same reset.
- MDU contract:
  - busy rises at the edge that samples start, except for mthi/mtlo, which leave busy 0 and write HI/LO at that edge.
  - busy falls at the same edge that HI/LO are written.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration: only port 0 valid → grant 0; only port 1 valid → grant 1; both valid → grant !last_grant.
  - req_ready of the winner is high this cycle.
  - At the edge: latch op, operands and id; update last_grant.
  - op==0 (READ): capture mdu_hi/mdu_lo into resp regs and go to RESP.
  - Otherwise go to ISSUE.
  - No request → stay in IDLE.
- ISSUE: mdu_start=1 with mdu_op/d1/d2 driven from the latches; next state WAIT; clear the WAIT counter.
- WAIT:
  - mdu_start=0.
  - mdu_busy==0 → capture mdu_hi/mdu_lo, resp_err=0, go to RESP.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 while busy: resp_err=1, err_sticky=1, resp regs keep their old values, go to RESP.
- RESP: resp_valid of the latched id =1 for exactly one cycle, then IDLE. No new accept in RESP, so back-to-back operations take at least one IDLE cycle.
- req_ready is never high outside IDLE. Requests arriving while the block is busy are held by the requester.
- mdu_op/d1/d2 hold their latched values between operations. MDU inputs are ignored when start=0.
- Latency, accept cycle T → resp_valid:
  - READ T+1
  - mthi/mtlo T+3
  - MDU latency-L ops T+L+3 (mult/multu L=5 → T+8; div/divu L=10 → T+13; fdiv L=3 → T+6)
- resp_hi/resp_lo persist after resp_valid until the next capture.

Test Plan:
- Reset, then port 0 mult with a=0xFFFFFFFE (-2), b=3 accepted at T → mdu_start high only at T+1; resp_valid_0 at T+8 with hi=0xFFFFFFFF, lo=0xFFFFFFFA; resp_valid_1 stays 0.
- Both ports valid every cycle with divu 100/7 → grants alternate 0,1,0,1 (first grant port 0); each response gives lo=14, hi=2, with resp_valid at the accept cycle +13.
- Port 1 mthi a=0x12345678 at T, then READ at the next IDLE → first resp_valid_1 at T+3; READ returns resp_hi=0x12345678 one cycle after its accept.
- Stub MDU holding busy=1 forever after start → resp_valid with resp_err=1 after TIMEOUT WAIT cycles; err_sticky=1 and stays 1 across later successful operations until reset.
- Assert reset during WAIT of a div → next cycle state is IDLE, all outputs 0, no resp_valid; a fresh multu 0xFFFFFFFF×2 then completes normally with hi=1, lo=0xFFFFFFFE.
- Port 0 drops req_valid for one cycle between two requests while port 1 stays valid → port 1 is granted in the gap; verify that no cycle ever has both req_ready high.
